// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the RV32 pipeline hazard controller.
//   fwd_sel_t   : operand forwarding select (register file / W result / M ALU result)
//   mem_state_t : data-memory handshake state (idle / waiting for acknowledge)
//   reg_match() : true when a source register is nonzero and equals a destination
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
        return (rs != REG_ZERO) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles every datapath-facing signal of the hazard controller.
//   master : datapath/controller side (drives register ids and status, receives
//            stall/flush/forward controls)
//   slave  : hazard controller side
// Parameter CNT_W sets the width of the performance counters.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
) ();
    import hazard_pkg::*;

    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemAccessM;
    logic             MemReadyM;
    logic             MemReqM;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    fwd_sel_t         ForwardAE;
    fwd_sel_t         ForwardBE;
    logic             MemTimeoutErr;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM,
        input  MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemTimeoutErr, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM,
        output MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemTimeoutErr, StallCnt, FlushCnt
    );

endinterface

// File: rtl/forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational forwarding select for one E-stage source operand.
//   rs_e        in  5  source register in E
//   rd_m, rd_w  in  5  destination registers in M and W
//   reg_write_m in  1  M instruction writes the register file
//   reg_write_w in  1  W instruction writes the register file
//   fwd_sel     out 2  FWD_M / FWD_W / FWD_RF (M has priority: it is the newer value)
// -----------------------------------------------------------------------------
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   fwd_sel
);

    // Pick the youngest in-flight producer of rs_e
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && reg_match(rs_e, rd_m)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_w && reg_match(rs_e, rd_w)) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall / flush / forward sequencing for the 5-stage RV32 pipeline, with a
// data-memory wait handshake that freezes F..M and bubbles W while an M-stage
// access is unacknowledged.
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous, active-high; forces all controls inactive
//   hz     slave modport of hazard_ctrl_if (register ids, handshake, controls,
//          saturating StallCnt/FlushCnt, sticky MemTimeoutErr)
// Parameters: CNT_W (counter width), MEM_TIMEOUT (WAIT cycles before timeout, >=1)
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam int                 WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    fwd_sel_t          fwd_a_s;
    fwd_sel_t          fwd_b_s;
    logic              lw_stall_s;
    logic              mem_stall_s;
    logic              mem_req_s;
    mem_state_t        state_r;
    mem_state_t        state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic              timeout_hit_s;
    logic              timeout_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic              stall_f_s;
    logic              stall_e_s;
    logic              flush_d_s;
    logic              flush_e_s;
    logic              flush_w_s;
    logic              mem_req_out_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    forward_unit u_fwd_a (
        .rs_e        (hz.Rs1E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd_sel     (fwd_a_s)
    );

    forward_unit u_fwd_b (
        .rs_e        (hz.Rs2E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd_sel     (fwd_b_s)
    );

    // Load in E whose destination is read by the instruction in D
    always_comb begin
        lw_stall_s = 1'b0;
        if (hz.ResultSrcE0 && (hz.RdE != REG_ZERO)) begin
            lw_stall_s = (hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE);
        end else begin
            lw_stall_s = 1'b0;
        end
    end

    // Memory handshake FSM: next state, request and freeze condition
    always_comb begin
        state_next_s = state_r;
        mem_req_s    = 1'b0;
        mem_stall_s  = 1'b0;
        case (state_r)
            MEM_IDLE: begin
                mem_req_s   = hz.MemAccessM;
                // Same-cycle acknowledge costs nothing.
                mem_stall_s = hz.MemAccessM && !hz.MemReadyM;
                if (mem_stall_s) begin
                    state_next_s = MEM_WAIT;
                end else begin
                    state_next_s = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                mem_req_s   = 1'b1;
                mem_stall_s = !hz.MemReadyM;
                if (hz.MemReadyM) begin
                    state_next_s = MEM_IDLE;
                end else begin
                    state_next_s = MEM_WAIT;
                end
            end
            default: begin
                state_next_s = MEM_IDLE;
                mem_req_s    = 1'b0;
                mem_stall_s  = 1'b0;
            end
        endcase
    end

    // Wait-cycle counter; holds at the limit so it cannot wrap during a long wait
    always_comb begin
        wait_cnt_next_s = {WAIT_W{1'b0}};
        timeout_hit_s   = 1'b0;
        if ((state_r == MEM_WAIT) && !hz.MemReadyM) begin
            if (wait_cnt_r != WAIT_LIMIT) begin
                wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_next_s = wait_cnt_r;
            end
            timeout_hit_s = (wait_cnt_next_s == WAIT_LIMIT);
        end else begin
            wait_cnt_next_s = {WAIT_W{1'b0}};
            timeout_hit_s   = 1'b0;
        end
    end

    // Stall/flush combine; a memory freeze defers branch and load-use actions
    always_comb begin
        stall_f_s     = 1'b0;
        stall_e_s     = 1'b0;
        flush_d_s     = 1'b0;
        flush_e_s     = 1'b0;
        flush_w_s     = 1'b0;
        mem_req_out_s = 1'b0;
        if (reset) begin
            stall_f_s     = 1'b0;
            mem_req_out_s = 1'b0;
        end else begin
            stall_f_s     = lw_stall_s | mem_stall_s;
            stall_e_s     = mem_stall_s;
            flush_w_s     = mem_stall_s;
            // With load-use and a taken branch together, flushing D discards
            // the dependent instruction, so the branch wins.
            flush_d_s     = hz.PCSrcE & ~mem_stall_s;
            flush_e_s     = (lw_stall_s | hz.PCSrcE) & ~mem_stall_s;
            mem_req_out_s = mem_req_s;
        end
    end

    // FSM state, wait counter, sticky timeout flag and saturating counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= MEM_IDLE;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            timeout_err_r <= 1'b0;
            stall_cnt_r   <= {CNT_W{1'b0}};
            flush_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end
            if (stall_f_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_d_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign hz.StallF        = stall_f_s;
    assign hz.StallD        = stall_f_s;
    assign hz.StallE        = stall_e_s;
    assign hz.StallM        = stall_e_s;
    assign hz.FlushD        = flush_d_s;
    assign hz.FlushE        = flush_e_s;
    assign hz.FlushW        = flush_w_s;
    assign hz.MemReqM       = mem_req_out_s;
    assign hz.ForwardAE     = reset ? FWD_RF : fwd_a_s;
    assign hz.ForwardBE     = reset ? FWD_RF : fwd_b_s;
    assign hz.MemTimeoutErr = timeout_err_r;
    assign hz.StallCnt      = stall_cnt_r;
    assign hz.FlushCnt      = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl with CNT_W=4 and MEM_TIMEOUT=4.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
// Control vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemReqM}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(4)) hz ();

    hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] ctl_vec();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW, hz.MemReqM};
    endfunction

    task automatic clear_inputs();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
        hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
        hz.ResultSrcE0 = 1'b0; hz.PCSrcE = 1'b0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemAccessM = 1'b0; hz.MemReadyM = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        hz.MemAccessM = 1'b1; hz.PCSrcE = 1'b1; hz.ResultSrcE0 = 1'b1;
        hz.RdE = 5'd3; hz.Rs1D = 5'd3;
        hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
        next_cycle();
        next_cycle();
        #2;
        n_checks++; if (ctl_vec() !== 8'b0000_0000) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl_vec(), 8'b0000_0000); end
        n_checks++; if (hz.ForwardAE !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b expected 00", hz.ForwardAE); end
        n_checks++; if (hz.ForwardBE !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b: got %b expected 00", hz.ForwardBE); end
        n_checks++; if (hz.StallCnt !== 4'd0) begin n_fail++; $display("FAIL reset_stallcnt: got %0d expected 0", hz.StallCnt); end
        n_checks++; if (hz.FlushCnt !== 4'd0) begin n_fail++; $display("FAIL reset_flushcnt: got %0d expected 0", hz.FlushCnt); end
        n_checks++; if (hz.MemTimeoutErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", hz.MemTimeoutErr); end
        next_cycle();
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        do_reset();
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
        #2;
        n_checks++; if (hz.ForwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_a_m: got %b expected 10", hz.ForwardAE); end
        n_checks++; if (hz.ForwardBE !== 2'b10) begin n_fail++; $display("FAIL fwd_b_m: got %b expected 10", hz.ForwardBE); end
        n_checks++; if (ctl_vec() !== 8'b0000_0000) begin n_fail++; $display("FAIL fwd_ctl: got %b expected 00000000", ctl_vec()); end
        hz.RegWriteM = 1'b0;
        #2;
        n_checks++; if (hz.ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_a_w: got %b expected 01", hz.ForwardAE); end
        hz.Rs1E = 5'd0;
        #2;
        n_checks++; if (hz.ForwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_a_x0: got %b expected 00", hz.ForwardAE); end
        n_checks++; if (hz.ForwardBE !== 2'b01) begin n_fail++; $display("FAIL fwd_b_w: got %b expected 01", hz.ForwardBE); end
        hz.Rs1E = 5'd9; hz.Rs2E = 5'd6; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd6;
        #2;
        n_checks++; if (hz.ForwardBE !== 2'b01) begin n_fail++; $display("FAIL fwd_b_rdm_miss: got %b expected 01", hz.ForwardBE); end
        n_checks++; if (hz.ForwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_a_nomatch: got %b expected 00", hz.ForwardAE); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd1; hz.Rs2D = 5'd7;
        #2;
        n_checks++; if (ctl_vec() !== 8'b1100_0100) begin n_fail++; $display("FAIL lu_rs2_ctl: got %b expected 11000100", ctl_vec()); end
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (ctl_vec() !== 8'b0000_0000) begin n_fail++; $display("FAIL lu_release_ctl: got %b expected 00000000", ctl_vec()); end
        n_checks++; if (hz.StallCnt !== 4'd1) begin n_fail++; $display("FAIL lu_stallcnt1: got %0d expected 1", hz.StallCnt); end
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd0;
        #2;
        n_checks++; if (ctl_vec() !== 8'b0000_0000) begin n_fail++; $display("FAIL lu_rd0_ctl: got %b expected 00000000", ctl_vec()); end
        next_cycle();
        hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.Rs2D = 5'd0;
        #2;
        n_checks++; if (hz.StallCnt !== 4'd1) begin n_fail++; $display("FAIL lu_rd0_cnt: got %0d expected 1", hz.StallCnt); end
        n_checks++; if (ctl_vec() !== 8'b1100_0100) begin n_fail++; $display("FAIL lu_rs1_ctl: got %b expected 11000100", ctl_vec()); end
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (hz.StallCnt !== 4'd2) begin n_fail++; $display("FAIL lu_stallcnt2: got %0d expected 2", hz.StallCnt); end
    endtask

    task automatic test_mem_wait();
        int stall_cycles;
        int req_cycles;
        logic [7:0] exp_ctl;
        do_reset();
        stall_cycles = 0;
        req_cycles   = 0;
        hz.MemAccessM = 1'b1;
        for (int k = 0; k < 4; k++) begin
            hz.MemReadyM = (k == 3) ? 1'b1 : 1'b0;
            exp_ctl = (k == 3) ? 8'b0000_0001 : 8'b1111_0011;
            #2;
            if (hz.StallM === 1'b1) stall_cycles++;
            if (hz.MemReqM === 1'b1) req_cycles++;
            n_checks++; if (ctl_vec() !== exp_ctl) begin n_fail++; $display("FAIL mem_ctl_k%0d: got %b expected %b", k, ctl_vec(), exp_ctl); end
            next_cycle();
        end
        clear_inputs();
        #2;
        n_checks++; if (stall_cycles !== 3) begin n_fail++; $display("FAIL mem_stall_cycles: got %0d expected 3", stall_cycles); end
        n_checks++; if (req_cycles !== 4) begin n_fail++; $display("FAIL mem_req_cycles: got %0d expected 4", req_cycles); end
        n_checks++; if (ctl_vec() !== 8'b0000_0000) begin n_fail++; $display("FAIL mem_idle_ctl: got %b expected 00000000", ctl_vec()); end
        n_checks++; if (hz.StallCnt !== 4'd3) begin n_fail++; $display("FAIL mem_stallcnt: got %0d expected 3", hz.StallCnt); end
        n_checks++; if (hz.MemTimeoutErr !== 1'b0) begin n_fail++; $display("FAIL mem_no_timeout: got %b expected 0", hz.MemTimeoutErr); end
        // back-to-back accesses acknowledged in the request cycle
        hz.MemAccessM = 1'b1; hz.MemReadyM = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_checks++; if (ctl_vec() !== 8'b0000_0001) begin n_fail++; $display("FAIL b2b_ctl_k%0d: got %b expected 00000001", k, ctl_vec()); end
            next_cycle();
        end
        clear_inputs();
        #2;
        n_checks++; if (hz.StallCnt !== 4'd3) begin n_fail++; $display("FAIL b2b_stallcnt: got %0d expected 3", hz.StallCnt); end
    endtask

    task automatic test_branch_in_wait();
        do_reset();
        hz.MemAccessM = 1'b1; hz.MemReadyM = 1'b0; hz.PCSrcE = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_checks++; if (ctl_vec() !== 8'b1111_0011) begin n_fail++; $display("FAIL br_wait_ctl_k%0d: got %b expected 11110011", k, ctl_vec()); end
            next_cycle();
        end
        hz.MemReadyM = 1'b1;
        #2;
        n_checks++; if (ctl_vec() !== 8'b0000_1101) begin n_fail++; $display("FAIL br_ack_ctl: got %b expected 00001101", ctl_vec()); end
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (hz.FlushCnt !== 4'd1) begin n_fail++; $display("FAIL br_flushcnt1: got %0d expected 1", hz.FlushCnt); end
        hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3; hz.PCSrcE = 1'b1;
        #2;
        n_checks++; if (ctl_vec() !== 8'b1100_1100) begin n_fail++; $display("FAIL br_lu_ctl: got %b expected 11001100", ctl_vec()); end
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (hz.FlushCnt !== 4'd2) begin n_fail++; $display("FAIL br_flushcnt2: got %0d expected 2", hz.FlushCnt); end
        n_checks++; if (hz.StallCnt !== 4'd3) begin n_fail++; $display("FAIL br_stallcnt: got %0d expected 3", hz.StallCnt); end
    endtask

    task automatic test_timeout();
        logic exp_err;
        do_reset();
        hz.MemAccessM = 1'b1; hz.MemReadyM = 1'b0;
        // cycle 0 is the IDLE request; cycles 1..4 are unacknowledged WAIT cycles
        for (int k = 0; k < 6; k++) begin
            exp_err = (k >= 5) ? 1'b1 : 1'b0;
            #2;
            n_checks++; if (hz.MemTimeoutErr !== exp_err) begin n_fail++; $display("FAIL to_err_k%0d: got %b expected %b", k, hz.MemTimeoutErr, exp_err); end
            next_cycle();
        end
        hz.MemReadyM = 1'b1;
        #2;
        n_checks++; if (ctl_vec() !== 8'b0000_0001) begin n_fail++; $display("FAIL to_ack_ctl: got %b expected 00000001", ctl_vec()); end
        next_cycle();
        clear_inputs();
        #2;
        n_checks++; if (hz.MemTimeoutErr !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", hz.MemTimeoutErr); end
        n_checks++; if (hz.MemReqM !== 1'b0) begin n_fail++; $display("FAIL to_idle_req: got %b expected 0", hz.MemReqM); end
        do_reset();
        #2;
        n_checks++; if (hz.MemTimeoutErr !== 1'b0) begin n_fail++; $display("FAIL to_cleared: got %b expected 0", hz.MemTimeoutErr); end
    endtask

    task automatic test_saturation_reset_mid_wait();
        do_reset();
        hz.MemAccessM = 1'b1; hz.MemReadyM = 1'b0;
        repeat (20) next_cycle();
        #2;
        n_checks++; if (hz.StallCnt !== 4'd15) begin n_fail++; $display("FAIL sat_stallcnt: got %0d expected 15", hz.StallCnt); end
        n_checks++; if (hz.MemReqM !== 1'b1) begin n_fail++; $display("FAIL sat_in_wait_req: got %b expected 1", hz.MemReqM); end
        n_checks++; if (hz.MemTimeoutErr !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b expected 1", hz.MemTimeoutErr); end
        reset = 1'b1;
        #2;
        n_checks++; if (ctl_vec() !== 8'b0000_0000) begin n_fail++; $display("FAIL midrst_forced_ctl: got %b expected 00000000", ctl_vec()); end
        next_cycle();
        reset = 1'b0;
        hz.MemAccessM = 1'b0;
        #2;
        n_checks++; if (hz.MemReqM !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_req: got %b expected 0", hz.MemReqM); end
        n_checks++; if (hz.StallCnt !== 4'd0) begin n_fail++; $display("FAIL midrst_stallcnt: got %0d expected 0", hz.StallCnt); end
        n_checks++; if (hz.FlushCnt !== 4'd0) begin n_fail++; $display("FAIL midrst_flushcnt: got %0d expected 0", hz.FlushCnt); end
        n_checks++; if (hz.MemTimeoutErr !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", hz.MemTimeoutErr); end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_branch_in_wait();
        test_timeout();
        test_saturation_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
